// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver.
// Optional parity support is selected in the receiver by UART_RX_PARITY_EN.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int TICKS_PER_BIT = 16;
    localparam int MID_TICK      = 7;

endpackage

// File: rtl/uart_rx_oversample_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Both flops reset to the idle-high line level.
module rx_sync (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_meta <= 1'b1;
            r_q    <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/uart_rx_oversample.sv
// 16x-oversampling 8N1 UART receiver (FSM and datapath).
// Define UART_RX_PARITY_EN to add a parity bit between data and stop.
module uart_rx_oversample
    import uart_pkg::*;
#(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_s_tick,
    input  logic            i_rx,
    output logic [DBIT-1:0] o_dout,
    output logic            o_rx_done_tick,
    output logic            o_frame_err,
    output logic            o_parity_err,
    output logic            o_busy
);

    localparam int SW = (SB_TICK > 16) ? 5 : 4;
    localparam int NW = 3;

    logic            w_rx_s;
    state_t          r_state, w_state;
    logic [SW-1:0]   r_s, w_s;
    logic [NW-1:0]   r_n, w_n;
    logic [DBIT-1:0] r_shreg, w_shreg;
    logic [DBIT-1:0] r_dout, w_dout;
    logic            r_done, w_done;
    logic            r_ferr, w_ferr;
    logic            r_perr, w_perr;
`ifdef UART_RX_PARITY_EN
    logic            r_par, w_par;
`endif

    rx_sync u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_rx),
        .o_q     (w_rx_s)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_shreg <= '0;
            r_dout  <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
            r_perr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state;
            r_s     <= w_s;
            r_n     <= w_n;
            r_shreg <= w_shreg;
            r_dout  <= w_dout;
            r_done  <= w_done;
            r_ferr  <= w_ferr;
            r_perr  <= w_perr;
`ifdef UART_RX_PARITY_EN
            r_par   <= w_par;
`endif
        end
    end

    always_comb begin
        w_state = r_state;
        w_s     = r_s;
        w_n     = r_n;
        w_shreg = r_shreg;
        w_dout  = r_dout;
        w_done  = 1'b0;
        w_ferr  = r_ferr;
        w_perr  = r_perr;
`ifdef UART_RX_PARITY_EN
        w_par   = r_par;
`endif
        unique case (r_state)
            IDLE: begin
                if (!w_rx_s) begin
                    w_state = START;
                    w_s     = '0;
                end
            end
            START: begin
                if (i_s_tick) begin
                    if (r_s == SW'(MID_TICK)) begin
                        // A start bit that is high again at mid-bit is a glitch
                        if (!w_rx_s) begin
                            w_state = DATA;
                            w_s     = '0;
                            w_n     = '0;
                        end else begin
                            w_state = IDLE;
                        end
                    end else begin
                        w_s = r_s + SW'(1);
                    end
                end
            end
            DATA: begin
                if (i_s_tick) begin
                    if (r_s == SW'(TICKS_PER_BIT - 1)) begin
                        w_s     = '0;
                        w_shreg = {w_rx_s, r_shreg[DBIT-1:1]};
                        if (r_n == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                            w_state = PARITY;
`else
                            w_state = STOP;
`endif
                        end else begin
                            w_n = r_n + NW'(1);
                        end
                    end else begin
                        w_s = r_s + SW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (i_s_tick) begin
                    if (r_s == SW'(TICKS_PER_BIT - 1)) begin
                        w_par   = w_rx_s;
                        w_s     = '0;
                        w_state = STOP;
                    end else begin
                        w_s = r_s + SW'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (i_s_tick) begin
                    if (r_s == SW'(SB_TICK - 1)) begin
                        w_done  = 1'b1;
                        w_dout  = r_shreg;
                        w_ferr  = ~w_rx_s;
`ifdef UART_RX_PARITY_EN
                        w_perr  = ((^r_shreg) ^ r_par) != 1'(PARITY_ODD);
`else
                        w_perr  = 1'b0;
`endif
                        w_state = IDLE;
                    end else begin
                        w_s = r_s + SW'(1);
                    end
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign o_dout         = r_dout;
    assign o_rx_done_tick = r_done;
    assign o_frame_err    = r_ferr;
    assign o_parity_err   = r_perr;
    assign o_busy         = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench for uart_rx_oversample with a fast tick divider.
// Parity frames are exercised when UART_RX_PARITY_EN is defined.
module tb_uart_rx_oversample;

    localparam int DIV = 10;
    localparam int BIT = 16 * DIV;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       s_tick = 1'b0;
    logic       rx;
    logic [7:0] dout;
    logic       done;
    logic       ferr;
    logic       perr;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int tcnt = 0;

    logic [7:0] q_dout[$];
    logic       q_ferr[$];
    logic       q_perr[$];

    uart_rx_oversample dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_s_tick       (s_tick),
        .i_rx           (rx),
        .o_dout         (dout),
        .o_rx_done_tick (done),
        .o_frame_err    (ferr),
        .o_parity_err   (perr),
        .o_busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tcnt == DIV - 1) begin
            tcnt   <= 0;
            s_tick <= 1'b1;
        end else begin
            tcnt   <= tcnt + 1;
            s_tick <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (done) begin
            q_dout.push_back(dout);
            q_ferr.push_back(ferr);
            q_perr.push_back(perr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input int clks);
        rx = v;
        repeat (clks) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic par,
                        input logic stop_v, input int stop_clks);
        drive(1'b0, BIT);
        for (int i = 0; i < 8; i++) drive(b[i], BIT);
        if (PAR_ON) drive(par, BIT);
        drive(stop_v, stop_clks);
        rx = 1'b1;
    endtask

    task automatic send_ok(input logic [7:0] b);
        send(b, ^b, 1'b1, BIT);
    endtask

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_dout", dout, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        drive(1'b1, BIT);

        send_ok(8'hA5);
        drive(1'b1, 2 * BIT);
        chk("t1_count", q_dout.size(), 1);
        chk("t1_dout", q_dout[0], 8'hA5);
        chk("t1_ferr", q_ferr[0], 0);
        chk("t1_busy", busy, 0);

        drive(1'b0, 5 * DIV);
        drive(1'b1, 2 * BIT);
        chk("t2_count", q_dout.size(), 1);
        chk("t2_dout", dout, 8'hA5);
        chk("t2_busy", busy, 0);

        send(8'h3C, ^(8'h3C), 1'b0, 10 * DIV);
        drive(1'b1, 2 * BIT);
        chk("t3_count", q_dout.size(), 2);
        chk("t3_dout", q_dout[1], 8'h3C);
        chk("t3_ferr", q_ferr[1], 1);
        chk("t3_ferr_hold", ferr, 1);

        send_ok(8'h00);
        send_ok(8'hFF);
        send_ok(8'h55);
        drive(1'b1, 2 * BIT);
        chk("t4_count", q_dout.size(), 5);
        chk("t4_b0", q_dout[2], 8'h00);
        chk("t4_b1", q_dout[3], 8'hFF);
        chk("t4_b2", q_dout[4], 8'h55);
        chk("t4_ferr0", q_ferr[2], 0);
        chk("t4_ferr2", q_ferr[4], 0);
        chk("t4_busy", busy, 0);

        drive(1'b0, BIT);
        drive(1'b1, BIT);
        drive(1'b0, BIT);
        drive(1'b0, BIT / 2);
        chk("t5_busy_pre", busy, 1);
        reset = 1'b1;
        rx    = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("t5_rst_dout", dout, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_ferr", ferr, 0);
        chk("t5_rst_perr", perr, 0);
        reset = 1'b0;
        drive(1'b1, 2 * BIT);
        send_ok(8'h42);
        drive(1'b1, 2 * BIT);
        chk("t5_count", q_dout.size(), 6);
        chk("t5_dout", q_dout[5], 8'h42);

`ifdef UART_RX_PARITY_EN
        send(8'h07, 1'b1, 1'b1, BIT);
        drive(1'b1, 2 * BIT);
        send(8'h07, 1'b0, 1'b1, BIT);
        drive(1'b1, 2 * BIT);
        chk("t6_count", q_dout.size(), 8);
        chk("t6_dout", q_dout[6], 8'h07);
        chk("t6_perr_ok", q_perr[6], 0);
        chk("t6_perr_bad", q_perr[7], 1);
`else
        chk("t6_perr_tied", perr, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
